// File: rtl/branch_pkg.sv
// Shared constants and stage payload layout for the EX-stage branch target pipeline.
package branch_pkg;

   localparam int PC_WORD_SHIFT  = 0;
   localparam int PC_BYTE_SHIFT  = 2;
   localparam int DEFAULT_DATA_W = 32;

   typedef struct packed {
      logic                      valid;
      logic                      taken;
      logic                      wrap;
      logic [DEFAULT_DATA_W-1:0] target;
   } bt_payload_t;

endpackage

// File: rtl/bt_stage_reg.sv
// One pipeline stage of the branch target unit: flush clears valid, stall holds,
// data only loads behind a valid entry.
module bt_stage_reg
   import branch_pkg::*;
#(
   parameter type payload_t = bt_payload_t
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     i_stall,
   input  logic     i_flush,
   input  payload_t i_d,
   output payload_t o_q
);

   payload_t r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= '0;
      end else if (i_flush) begin
         r_q.valid <= 1'b0;
      end else if (!i_stall) begin
         r_q.valid <= i_d.valid;
         if (i_d.valid) begin
            r_q.taken  <= i_d.taken;
            r_q.wrap   <= i_d.wrap;
            r_q.target <= i_d.target;
         end
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/branch_target_ex.sv
// EX-stage branch target adder with 1- or 2-stage output pipeline.
// Optional taken-branch counter enabled by macro BRANCH_TARGET_STATS_EN.
module branch_target_ex
   import branch_pkg::*;
#(
   parameter int DATA_W    = DEFAULT_DATA_W,
   parameter int OFS_SHIFT = PC_WORD_SHIFT,
   parameter int STAGES    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic              stall,
   input  logic              flush,
   input  logic [DATA_W-1:0] pc_next,
   input  logic [DATA_W-1:0] sign_ext,
   input  logic              is_branch,
   input  logic              zero,
   input  logic              stats_clr,
   output logic              out_valid,
   output logic [DATA_W-1:0] target,
   output logic              taken,
   output logic              wrap,
   output logic [15:0]       taken_cnt
);

   generate
      if (STAGES < 1 || STAGES > 2) begin : g_bad_stages
         $error("branch_target_ex: STAGES must be 1 or 2");
      end
      if (OFS_SHIFT >= DATA_W) begin : g_bad_shift
         $error("branch_target_ex: OFS_SHIFT must be below DATA_W");
      end
   endgenerate

   typedef struct packed {
      logic              valid;
      logic              taken;
      logic              wrap;
      logic [DATA_W-1:0] target;
   } stage_t;

   logic [DATA_W-1:0] w_ofs_p0;
   logic [DATA_W:0]   w_sum_p0;
   stage_t            w_in_p0;
   stage_t            w_stg [1:STAGES];

   // Stage 0: combinational target; carry-out against the offset sign flags a wrap
   assign w_ofs_p0 = sign_ext << OFS_SHIFT;
   assign w_sum_p0 = {1'b0, pc_next} + {1'b0, w_ofs_p0};

   always_comb begin
      w_in_p0        = '0;
      w_in_p0.valid  = in_valid;
      w_in_p0.taken  = is_branch & zero;
      w_in_p0.wrap   = w_ofs_p0[DATA_W-1] ^ w_sum_p0[DATA_W];
      w_in_p0.target = w_sum_p0[DATA_W-1:0];
   end

   generate
      for (genvar g = 1; g <= STAGES; g++) begin : g_stage
         if (g == 1) begin : g_first
            bt_stage_reg #(.payload_t(stage_t)) u_stage (
               .clk     (clk),
               .rst_n   (rst_n),
               .i_stall (stall),
               .i_flush (flush),
               .i_d     (w_in_p0),
               .o_q     (w_stg[g])
            );
         end else begin : g_next
            bt_stage_reg #(.payload_t(stage_t)) u_stage (
               .clk     (clk),
               .rst_n   (rst_n),
               .i_stall (stall),
               .i_flush (flush),
               .i_d     (w_stg[g-1]),
               .o_q     (w_stg[g])
            );
         end
      end
   endgenerate

   assign out_valid = w_stg[STAGES].valid;
   assign target    = w_stg[STAGES].target;
   assign taken     = w_stg[STAGES].valid & w_stg[STAGES].taken;
   assign wrap      = w_stg[STAGES].valid & w_stg[STAGES].wrap;

`ifdef BRANCH_TARGET_STATS_EN
   stage_t      w_last_in;
   logic        w_cnt_inc;
   logic [15:0] r_taken_cnt;

   generate
      if (STAGES == 1) begin : g_last_in1
         assign w_last_in = w_in_p0;
      end else begin : g_last_in2
         assign w_last_in = w_stg[STAGES-1];
      end
   endgenerate

   // Count when a taken entry actually lands in the last stage
   assign w_cnt_inc = w_last_in.valid & w_last_in.taken & ~stall & ~flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_taken_cnt <= '0;
      end else if (stats_clr) begin
         r_taken_cnt <= '0;
      end else if (w_cnt_inc && (r_taken_cnt != 16'hFFFF)) begin
         r_taken_cnt <= r_taken_cnt + 16'd1;
      end
   end

   assign taken_cnt = r_taken_cnt;
`else
   logic w_unused_stats;
   assign w_unused_stats = stats_clr;
   assign taken_cnt      = '0;
`endif

endmodule

// File: doc/branch_target_ex.md
BRANCH_TARGET_EX -- requirements
Module: branch_target_ex

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width of PC, offset and target.
REQ-002 SHALL have parameter OFS_SHIFT, default 0, left-shift applied to the offset: 0 = word-addressed PC, 2 = byte-addressed PC.
REQ-003 SHALL have parameter STAGES, default 1, number of pipeline register stages; legal values 1 or 2.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port: clk  input  1  rising-edge clock.
REQ-006 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port: in_valid  input  1  EX-stage entry present this cycle.
REQ-008 SHALL have port: stall  input  1  hold all stages.
REQ-009 SHALL have port: flush  input  1  invalidate all stages.
REQ-010 SHALL have port: pc_next  input  DATA_W  PC of the following instruction.
REQ-011 SHALL have port: sign_ext  input  DATA_W  sign-extended branch immediate.
REQ-012 SHALL have port: is_branch  input  1  instruction is a conditional branch.
REQ-013 SHALL have port: zero  input  1  ALU zero flag.
REQ-014 SHALL have port: stats_clr  input  1  synchronous clear of taken counter.
REQ-015 SHALL have port: out_valid  output  1  last stage holds a valid entry.
REQ-016 SHALL have port: target  output  DATA_W  branch target address.
REQ-017 SHALL have port: taken  output  1  branch taken.
REQ-018 SHALL have port: wrap  output  1  target wrapped outside the address space.
REQ-019 SHALL have port: taken_cnt  output  16  saturating count of taken branches.

Function
REQ-020 SHALL compute ofs = (sign_ext << OFS_SHIFT) truncated to DATA_W bits.
REQ-021 SHALL compute target = (pc_next + ofs) mod 2^DATA_W.
REQ-022 SHALL compute wrap = (ofs MSB = 0 and carry-out = 1) or (ofs MSB = 1 and carry-out = 0).
REQ-023 SHALL compute taken = is_branch and zero.
REQ-024 SHALL present results STAGES cycles after the capturing edge; stage 1 computes, stage 2 (if present) only re-registers.
REQ-025 SHALL, when stall = 1 and flush = 0, hold every stage's valid and data unchanged.
REQ-026 SHALL, when flush = 1, clear every stage's valid at the next edge regardless of stall (flush wins).
REQ-027 SHALL, with no stall/flush, load stage valid from upstream valid each cycle.
REQ-028 SHALL load a stage's data registers only when its incoming valid = 1; otherwise data hold.
REQ-029 SHALL force taken and wrap to 0 whenever out_valid = 0; target is don't-care then.

Reset
REQ-030 SHALL on rst_n = 0 asynchronously clear all stage valids, target, taken, wrap and taken_cnt to 0.
REQ-031 SHALL, on reset asserted mid-operation, drop in-flight entries with no partial output.
REQ-032 SHALL accept no entry on the first rising edge while rst_n is low.

Configuration
REQ-033 SHALL, with macro BRANCH_TARGET_STATS_EN defined, increment taken_cnt by 1 on each edge where a valid, taken entry loads into the last stage (no stall, no flush).
REQ-034 SHALL saturate taken_cnt at 0xFFFF; stats_clr = 1 sets it to 0 next edge and overrides a same-cycle increment; flush does not clear it.
REQ-035 SHALL, without BRANCH_TARGET_STATS_EN, keep the taken_cnt and stats_clr ports, tie taken_cnt to 0, ignore stats_clr and infer no counter flops.

Structure
REQ-036 SHALL place PC_WORD_SHIFT = 0, PC_BYTE_SHIFT = 2, DEFAULT_DATA_W = 32 and the stage payload typedef (valid, target, taken, wrap) in shared package branch_pkg.
REQ-037 SHALL implement one stage register as sub-module bt_stage_reg, instantiated STAGES times with stall/flush/valid-gated load.
REQ-038 SHALL reject STAGES outside {1, 2} and OFS_SHIFT >= DATA_W at elaboration.

Verification
REQ-039 SHALL cover: OFS_SHIFT=0, pc_next=0x10, sign_ext=0xFFFFFFFC, is_branch=1, zero=1 -> after STAGES cycles target=0x0C, taken=1, wrap=0.
REQ-040 SHALL cover: OFS_SHIFT=2, pc_next=0x100, sign_ext=0x3, zero=0 -> target=0x10C, taken=0.
REQ-041 SHALL cover: pc_next=0xFFFFFFF0, sign_ext=0x20, OFS_SHIFT=0 -> target=0x10, wrap=1; pc_next=0x8, sign_ext=0xFFFFFFF0 -> target=0xFFFFFFF8, wrap=1.
REQ-042 SHALL cover: STAGES=2, stall held 3 cycles mid-flight -> outputs frozen, then emerge in order; flush with stall same cycle -> out_valid=0 next edge.
REQ-043 SHALL cover: BRANCH_TARGET_STATS_EN, taken_cnt preloaded by 65535 taken branches, one more -> stays 0xFFFF; stats_clr with a taken load same cycle -> 0.
REQ-044 SHALL cover: rst_n pulsed low between edges with valid entries in flight -> out_valid, taken, wrap, taken_cnt 0 immediately, no output after release.
